// File: rtl/iter_div_pkg.sv
// iter_div_pkg: shared widths and state encodings for the iterative divider.
package iter_div_pkg;

    // Default operand/result width and iteration counter width (2**CNT_W > DIV_W).
    localparam int DIV_W_DEF = 32;
    localparam int CNT_W_DEF = 6;

    // Divider FSM encodings, kept as plain vectors for legacy tool compatibility.
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

endpackage : iter_div_pkg

// File: rtl/iter_div_if.sv
// iter_div_if: request/result bundle between exe_stage (master) and the divider (slave).
interface iter_div_if
    import iter_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             div_en;
    logic             div_signed;
    logic [DIV_W-1:0] x;
    logic [DIV_W-1:0] y;
    logic [DIV_W-1:0] s;
    logic [DIV_W-1:0] r;
    logic             complete;
    logic             busy;

    modport master (
        output div_en, div_signed, x, y,
        input  s, r, complete, busy
    );

    modport slave (
        input  div_en, div_signed, x, y,
        output s, r, complete, busy
    );

endinterface : iter_div_if

// File: rtl/iter_div_step.sv
// iter_div_step: one combinational restoring-division step (shift in a dividend
// bit, trial-subtract the divisor, keep the difference when it does not underflow).
module iter_div_step
    import iter_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic [DIV_W-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W-1:0] rem_o,
    output logic             q_bit_o
);

    // One extra bit so a partial remainder near 2**DIV_W-1 shifted left is not lost
    // when dividing by a large unsigned divisor.
    logic [DIV_W:0] shifted;

    assign shifted = {rem_i, dvd_bit_i};
    assign q_bit_o = (shifted >= {1'b0, dvs_i});
    // The difference is always < divisor, so only the low DIV_W bits are needed.
    assign rem_o   = q_bit_o ? (shifted[DIV_W-1:0] - dvs_i) : shifted[DIV_W-1:0];

endmodule : iter_div_step

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Operands are latched on acceptance; one quotient bit is produced per cycle, MSB first.
// Optional build macro DIV_FASTPATH_EN: divide-by-zero and |x| < |y| finish
// straight from IDLE (complete in the cycle after acceptance); results are unchanged.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    iter_div_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

    // Two's-complement negate when requested; used for magnitudes and sign fix-up.
    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + DIV_W'(1)) : v;
    endfunction

    // Final result with sign correction; divide-by-zero overrides the datapath result.
    function automatic logic [DIV_W-1:0] fix_quo(input logic [DIV_W-1:0] q,
                                                 input logic qneg, input logic yzero);
        return yzero ? '1 : neg_if(q, qneg);
    endfunction

    function automatic logic [DIV_W-1:0] fix_rem(input logic [DIV_W-1:0] rem,
                                                 input logic rneg, input logic yzero,
                                                 input logic [DIV_W-1:0] xraw);
        return yzero ? xraw : neg_if(rem, rneg);
    endfunction

    // Control state (asynchronously reset).
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] s_q, s_d;
    logic [DIV_W-1:0] r_q, r_d;
    logic             complete_q, complete_d;

    // Datapath state (no reset needed: always loaded on acceptance).
    logic [DIV_W-1:0] dvd_q, dvd_d;     // dividend magnitude, shifted left each step
    logic [DIV_W-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [DIV_W-1:0] rem_q, rem_d;     // partial remainder
    logic [DIV_W-1:0] quo_q, quo_d;     // quotient bits collected so far
    logic [DIV_W-1:0] xraw_q, xraw_d;   // original dividend, for the y == 0 remainder
    logic             yzero_q, yzero_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    // Operand decode for the accepting cycle.
    logic             x_neg, y_neg;
    logic [DIV_W-1:0] x_mag, y_mag;
    logic             accept;

    assign x_neg  = bus.div_signed & bus.x[DIV_W-1];
    assign y_neg  = bus.div_signed & bus.y[DIV_W-1];
    assign x_mag  = neg_if(bus.x, x_neg);
    assign y_mag  = neg_if(bus.y, y_neg);
    assign accept = (state_q == DIV_IDLE) && bus.div_en;

    // Restoring step on the current partial remainder.
    logic [DIV_W-1:0] step_rem;
    logic             step_q;
    logic [DIV_W-1:0] quo_next;

    iter_div_step #(.DIV_W(DIV_W)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[DIV_W-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    assign quo_next = {quo_q[DIV_W-2:0], step_q};

    // FSM next state, counter and registered result/complete generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        r_d        = r_q;
        complete_d = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (bus.div_en) begin
`ifdef DIV_FASTPATH_EN
                    if (bus.y == '0) begin
                        state_d    = DIV_DONE;
                        s_d        = '1;
                        r_d        = bus.x;
                        complete_d = 1'b1;
                    end else if (x_mag < y_mag) begin
                        state_d    = DIV_DONE;
                        s_d        = '0;
                        r_d        = bus.x;
                        complete_d = 1'b1;
                    end else begin
                        state_d = DIV_BUSY;
                        cnt_d   = '0;
                    end
`else
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
`endif
                end
            end
            DIV_BUSY: begin
                if (!bus.div_en) begin
                    // Flush from exe_stage: abandon quietly, results untouched.
                    state_d = DIV_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d    = DIV_DONE;
                        complete_d = 1'b1;
                        s_d        = fix_quo(quo_next, qneg_q, yzero_q);
                        r_d        = fix_rem(step_rem, rneg_q, yzero_q, xraw_q);
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // Datapath next state: latch operands on accept, otherwise advance one step.
    always_comb begin
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        xraw_d  = xraw_q;
        yzero_d = yzero_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (accept) begin
            dvd_d   = x_mag;
            dvs_d   = y_mag;
            rem_d   = '0;
            quo_d   = '0;
            xraw_d  = bus.x;
            yzero_d = (bus.y == '0);
            qneg_d  = bus.div_signed & (bus.x[DIV_W-1] ^ bus.y[DIV_W-1]);
            rneg_d  = x_neg;
        end else if (state_q == DIV_BUSY) begin
            dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
            rem_d = step_rem;
            quo_d = quo_next;
        end
    end

    // Control and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            complete_q <= complete_d;
        end
    end

    // Datapath registers; contents only matter after an accept reloads them.
    always_ff @(posedge clk) begin
        dvd_q   <= dvd_d;
        dvs_q   <= dvs_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        xraw_q  <= xraw_d;
        yzero_q <= yzero_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.complete = complete_q;
    assign bus.busy     = (state_q != DIV_IDLE);

endmodule : iter_div
